// File: rtl/uart_pkg.sv
// Shared UART definitions: word length, arbiter state encoding and
// elaboration-time helpers used across the TX/RX slice.
package uart_pkg;

   localparam int UART_WORD_LENGTH = 8;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      GRANT     = 3'd1,
      TRIGGER   = 3'd2,
      WAIT_BUSY = 3'd3,
      WAIT_DONE = 3'd4,
      GUARD     = 3'd5
   } arb_state_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Round-robin picker: first asserted request at or after the pointer,
// wrapping, found by a priority encode over a doubled request vector.
module rr_picker
   import uart_pkg::*;
#(
   parameter int N_REQ = 4,
   localparam int IW = clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic [IW-1:0]    winner,
   output logic             valid
);

   logic [2*N_REQ-1:0] cand;
   logic               found;

   always_comb begin
      cand   = {req, req};
      winner = '0;
      found  = 1'b0;
      valid  = |req;
      // Lower copy below the pointer is masked; upper copy supplies the wrap
      for (int i = 0; i < 2 * N_REQ; i++)
         if (i < int'(ptr)) cand[i] = 1'b0;
      for (int i = 0; i < 2 * N_REQ; i++) begin
         if (!found && cand[i]) begin
            found  = 1'b1;
            winner = IW'(i % N_REQ);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter: capture the winner's word,
// pulse the TX start, follow tx_busy, then hold a stop-bit guard.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ        = 4,
   parameter int WORD_LENGTH  = UART_WORD_LENGTH,
   parameter int GUARD_CYCLES = 14,
   parameter int START_TMO    = 255,
   localparam int IW = clog2(N_REQ)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [N_REQ-1:0]             req,
   input  logic [N_REQ*WORD_LENGTH-1:0] req_data,
   output logic [N_REQ-1:0]             ack,
   output logic [IW-1:0]                grant_id,
   output logic [WORD_LENGTH-1:0]       tx_data,
   output logic                         tx_transmit,
   input  logic                         tx_busy,
   output logic                         busy,
   output logic                         timeout_err
);

   localparam int CW = clog2(max2(START_TMO, GUARD_CYCLES) + 1);

   arb_state_e             state_q, state_d;
   logic [IW-1:0]          ptr_q, ptr_d;
   logic [IW-1:0]          grant_q, grant_d;
   logic [WORD_LENGTH-1:0] data_q, data_d;
   logic [N_REQ-1:0]       ack_q, ack_d;
   logic                   txs_q, txs_d;
   logic                   busy_q, busy_d;
   logic                   terr_q, terr_d;
   logic [CW-1:0]          tmo_q, tmo_d;
   logic [CW-1:0]          gcnt_q, gcnt_d;

   logic [IW-1:0]          win;
   logic                   win_vld;

   rr_picker #(.N_REQ(N_REQ)) u_pick (
      .req    (req),
      .ptr    (ptr_q),
      .winner (win),
      .valid  (win_vld)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      data_d  = data_q;
      ack_d   = '0;
      txs_d   = 1'b0;
      terr_d  = 1'b0;
      tmo_d   = tmo_q;
      gcnt_d  = gcnt_q;
      case (state_q)
         IDLE: begin
            if (win_vld) begin
               state_d    = GRANT;
               grant_d    = win;
               data_d     = req_data[int'(win)*WORD_LENGTH +: WORD_LENGTH];
               ptr_d      = (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
               ack_d[win] = 1'b1;
            end
         end
         GRANT: begin
            state_d = TRIGGER;
            txs_d   = 1'b1;
         end
         TRIGGER: begin
            tmo_d   = '0;
            state_d = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (tx_busy) begin
               state_d = WAIT_DONE;
            end else begin
               tmo_d = tmo_q + 1'b1;
               if (tmo_d == CW'(START_TMO - 1)) begin
                  terr_d  = 1'b1;
                  gcnt_d  = '0;
                  state_d = GUARD;
               end
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               gcnt_d  = '0;
               state_d = GUARD;
            end
         end
         GUARD: begin
            gcnt_d = gcnt_q + 1'b1;
            if (gcnt_q == CW'(GUARD_CYCLES - 1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         data_q  <= '0;
         ack_q   <= '0;
         txs_q   <= 1'b0;
         busy_q  <= 1'b0;
         terr_q  <= 1'b0;
         tmo_q   <= '0;
         gcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         data_q  <= data_d;
         ack_q   <= ack_d;
         txs_q   <= txs_d;
         busy_q  <= busy_d;
         terr_q  <= terr_d;
         tmo_q   <= tmo_d;
         gcnt_q  <= gcnt_d;
      end
   end

   assign ack         = ack_q;
   assign grant_id    = grant_q;
   assign tx_data     = data_q;
   assign tx_transmit = txs_q;
   assign busy        = busy_q;
   assign timeout_err = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: rounds of requests are expanded
// into an expected frame order; a monitor checks acks, starts and timing.
module tb_uart_tx_arbiter;

   localparam int N   = 4;
   localparam int W   = 8;
   localparam int G   = 14;
   localparam int TMO = 255;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic [N-1:0]   req = '0;
   logic [N*W-1:0] req_data = '0;
   logic           tx_busy = 1'b0;
   logic [N-1:0]   ack;
   logic [1:0]     grant_id;
   logic [W-1:0]   tx_data;
   logic           tx_transmit;
   logic           busy;
   logic           timeout_err;

   uart_tx_arbiter #(
      .N_REQ(N), .WORD_LENGTH(W), .GUARD_CYCLES(G), .START_TMO(TMO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .req_data    (req_data),
      .ack         (ack),
      .grant_id    (grant_id),
      .tx_data     (tx_data),
      .tx_transmit (tx_transmit),
      .tx_busy     (tx_busy),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input bit ok, input string name,
                        input int act, input int exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   typedef struct { int id; int data; } frame_t;
   frame_t exp_q[$];
   int     tmo_q[$];
   int     ptr_m = 0;

   int first_ack_exp = -1;
   int next_ack_exp  = -1;
   int idle_exp      = -1;
   int last_ack_cyc  = -10;
   int last_data     = 0;
   bit prev_busy     = 1'b0;
   bit prev_dbusy    = 1'b0;
   bit xmit_seen     = 1'b0;
   bit force_normal  = 1'b0;
   frame_t mf;
   int     mt;

   // Monitor: everything compared against queued expectations
   always @(negedge clk) begin
      if (!reset) begin
         prev_busy  = 1'b0;
         prev_dbusy = 1'b0;
      end else begin
         if (ack != '0) begin
            if (exp_q.size() == 0) begin
               check(1'b0, "unexpected_ack", int'(ack), 0);
            end else begin
               mf = exp_q.pop_front();
               check(int'(ack) == (1 << mf.id), "ack_vec", int'(ack), 1 << mf.id);
               check(int'(grant_id) == mf.id, "grant_id", int'(grant_id), mf.id);
               check(int'(tx_data) == mf.data, "grant_data", int'(tx_data), mf.data);
               last_data = mf.data;
            end
            if (first_ack_exp >= 0) begin
               check(cyc == first_ack_exp, "ack_latency", cyc, first_ack_exp);
               first_ack_exp = -1;
            end
            if (next_ack_exp >= 0) begin
               check(cyc == next_ack_exp, "guard_to_ack", cyc, next_ack_exp);
               next_ack_exp = -1;
            end
            last_ack_cyc = cyc;
            xmit_seen    = 1'b0;
         end
         if (tx_transmit) begin
            check(cyc == last_ack_cyc + 1, "xmit_latency", cyc, last_ack_cyc + 1);
            check(int'(tx_data) == last_data, "xmit_data", int'(tx_data), last_data);
            xmit_seen = 1'b1;
         end
         if (timeout_err) begin
            if (tmo_q.size() == 0) begin
               check(1'b0, "unexpected_timeout", 1, 0);
            end else begin
               mt = tmo_q.pop_front();
               check(cyc == mt, "timeout_cycle", cyc, mt);
            end
            idle_exp = cyc + G;
            if (exp_q.size() > 0) next_ack_exp = cyc + G + 1;
         end
         if (prev_busy && !tx_busy) begin
            idle_exp = cyc + G + 1;
            if (exp_q.size() > 0) next_ack_exp = cyc + G + 2;
         end
         if (prev_dbusy && !busy && idle_exp >= 0) begin
            check(cyc == idle_exp, "guard_to_idle", cyc, idle_exp);
            idle_exp = -1;
         end
         prev_busy  = tx_busy;
         prev_dbusy = busy;
      end
   end

   // Requesters hold req until their ack, then drop it
   always @(posedge clk) begin
      #2;
      if (reset) req = req & ~ack;
   end

   // Transmitter model: normal, busy-already-high, or never-busy
   int tmode = 2;
   int dly = 0;
   int left = 0;
   int blen = 1;
   int rsel;
   always @(posedge clk) begin
      #1;
      if (!reset) begin
         tx_busy = 1'b0;
         dly     = 0;
         left    = 0;
      end else begin
         if (tx_busy) begin
            left--;
            if (left <= 0) tx_busy = 1'b0;
         end else if (dly > 0) begin
            dly--;
            if (dly == 0) begin
               tx_busy = 1'b1;
               left    = blen;
            end
         end
         if (ack != '0) begin
            rsel = $urandom_range(0, 7);
            tmode = force_normal ? 2 : (rsel == 0) ? 0 : (rsel == 1) ? 1 : 2;
            if (tmode == 1) begin
               tx_busy = 1'b1;
               left    = $urandom_range(3, 10);
            end
         end
         if (tx_transmit) begin
            if (tmode == 0) begin
               tmo_q.push_back(cyc + TMO);
            end else if (tmode == 2) begin
               dly  = $urandom_range(1, 3);
               blen = $urandom_range(1, 12);
            end
         end
      end
   end

   task automatic wait_idle();
      int budget;
      budget = 5000;
      while (!(exp_q.size() == 0 && tmo_q.size() == 0 && !busy && req == '0)
             && budget > 0) begin
         @(posedge clk);
         #3;
         budget--;
      end
      if (budget == 0) check(1'b0, "idle_timeout", int'(busy), 0);
   endtask

   task automatic issue_round(input logic [N-1:0] m, input logic [N*W-1:0] dv);
      int id;
      int last;
      wait_idle();
      last = ptr_m;
      for (int k = 0; k < N; k++) begin
         id = (ptr_m + k) % N;
         if (m[id]) begin
            exp_q.push_back('{id, int'(dv[id*W +: W])});
            last = id;
         end
      end
      ptr_m         = (last + 1) % N;
      req_data      = dv;
      req           = m;
      first_ack_exp = cyc + 1;
   endtask

   task automatic check_zero_outputs(input string tag);
      check(ack == '0, {tag, "_ack"}, int'(ack), 0);
      check(grant_id == '0, {tag, "_grant_id"}, int'(grant_id), 0);
      check(tx_data == '0, {tag, "_tx_data"}, int'(tx_data), 0);
      check(!tx_transmit, {tag, "_tx_transmit"}, int'(tx_transmit), 0);
      check(!busy, {tag, "_busy"}, int'(busy), 0);
      check(!timeout_err, {tag, "_timeout_err"}, int'(timeout_err), 0);
   endtask

   logic [N*W-1:0] dv;
   logic [N-1:0]   m;
   int             budget;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_zero_outputs("reset");
      @(posedge clk);
      #3;
      reset = 1'b1;

      for (int r = 0; r < 34; r++) begin
         for (int i = 0; i < N; i++) dv[i*W +: W] = W'($urandom_range(0, 255));
         case (r)
            0: begin m = 4'b0100; dv[2*W +: W] = 8'hA5; end
            1: begin m = 4'b1111; dv = 32'h44332211; end
            2: m = 4'b0100;
            3: m = 4'b1001;
            default: m = N'($urandom_range(1, 15));
         endcase
         issue_round(m, dv);
      end

      // Reset while the transmitter is mid-frame
      force_normal = 1'b1;
      for (int i = 0; i < N; i++) dv[i*W +: W] = W'($urandom_range(0, 255));
      issue_round(4'b1111, dv);
      budget = 2000;
      while (!(xmit_seen && tx_busy) && budget > 0) begin
         @(posedge clk);
         #3;
         budget--;
      end
      if (budget == 0) check(1'b0, "reach_wait_done", 0, 1);
      reset = 1'b0;
      #1;
      check_zero_outputs("mid_reset");
      exp_q.delete();
      tmo_q.delete();
      ptr_m         = 0;
      req           = '0;
      first_ack_exp = -1;
      next_ack_exp  = -1;
      idle_exp      = -1;
      force_normal  = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b1;

      for (int i = 0; i < N; i++) dv[i*W +: W] = W'($urandom_range(0, 255));
      issue_round(4'b0010, dv);
      for (int i = 0; i < N; i++) dv[i*W +: W] = W'($urandom_range(0, 255));
      issue_round(4'b1011, dv);

      wait_idle();
      repeat (G + 4) @(posedge clk);
      #3;
      check(exp_q.size() == 0, "frames_left", exp_q.size(), 0);
      check(tmo_q.size() == 0, "timeouts_left", tmo_q.size(), 0);
      check(first_ack_exp == -1, "ack_pending", first_ack_exp, -1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
